// File: rtl/frag_dest_fetch_pkg.sv
// Shared constants and fragment attribute type for the per-fragment stage.
// Width defaults here are reused by frag_dest_fetch and downstream stages.
package frag_dest_fetch_pkg;

    localparam int DEF_FRAMEBUFFER_INDEX_WIDTH = 14;
    localparam int DEF_SCREEN_POS_WIDTH        = 16;
    localparam int DEF_DEPTH_WIDTH             = 16;
    localparam int DEF_STENCIL_WIDTH           = 4;
    localparam int DEF_PIXEL_WIDTH             = 32;
    localparam int DEF_HAZARD_DEPTH            = 8;
    localparam int FRAG_DEPTH_WIDTH            = 32;

    typedef struct packed {
        logic [DEF_PIXEL_WIDTH-1:0]             color;
        logic [FRAG_DEPTH_WIDTH-1:0]            depth;
        logic [DEF_FRAMEBUFFER_INDEX_WIDTH-1:0] index;
        logic [DEF_SCREEN_POS_WIDTH-1:0]        pos_x;
        logic [DEF_SCREEN_POS_WIDTH-1:0]        pos_y;
        logic                                   last;
        logic                                   keep;
    } frag_attr_t;

endpackage

// File: rtl/frag_dest_fetch_if.sv
// Bus bundle of frag_dest_fetch: fragment in/out streams, tile-buffer read port, write-back retire.
// slave = the fetch block, master = its surrounding environment.
interface frag_dest_fetch_if
    import frag_dest_fetch_pkg::*;
#(
    parameter int FRAMEBUFFER_INDEX_WIDTH = DEF_FRAMEBUFFER_INDEX_WIDTH,
    parameter int SCREEN_POS_WIDTH        = DEF_SCREEN_POS_WIDTH,
    parameter int DEPTH_WIDTH             = DEF_DEPTH_WIDTH,
    parameter int STENCIL_WIDTH           = DEF_STENCIL_WIDTH,
    parameter int PIXEL_WIDTH             = DEF_PIXEL_WIDTH
) ();
    logic                               s_frag_tvalid;
    logic                               s_frag_tready;
    logic                               s_frag_tlast;
    logic                               s_frag_tkeep;
    logic [PIXEL_WIDTH-1:0]             s_frag_tcolor;
    logic [FRAG_DEPTH_WIDTH-1:0]        s_frag_tdepth;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_frag_tindex;
    logic [SCREEN_POS_WIDTH-1:0]        s_frag_tscreenPosX;
    logic [SCREEN_POS_WIDTH-1:0]        s_frag_tscreenPosY;

    logic                               rd_en;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] rd_addr;
    logic [PIXEL_WIDTH-1:0]             rd_color;
    logic [DEPTH_WIDTH-1:0]             rd_depth;
    logic [STENCIL_WIDTH-1:0]           rd_stencil;
    logic                               wb_done;

    logic                               m_frag_tvalid;
    logic                               m_frag_tready;
    logic                               m_frag_tlast;
    logic                               m_frag_tkeep;
    logic [PIXEL_WIDTH-1:0]             m_frag_tcolor;
    logic [FRAG_DEPTH_WIDTH-1:0]        m_frag_tdepth;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_frag_tindex;
    logic [SCREEN_POS_WIDTH-1:0]        m_frag_tscreenPosX;
    logic [SCREEN_POS_WIDTH-1:0]        m_frag_tscreenPosY;
    logic [PIXEL_WIDTH-1:0]             m_frag_tdestinationColor;
    logic [DEPTH_WIDTH-1:0]             m_frag_tdestinationDepth;
    logic [STENCIL_WIDTH-1:0]           m_frag_tdestinationStencil;

    modport slave (
        input  s_frag_tvalid, s_frag_tlast, s_frag_tkeep, s_frag_tcolor, s_frag_tdepth,
               s_frag_tindex, s_frag_tscreenPosX, s_frag_tscreenPosY,
        output s_frag_tready,
        output rd_en, rd_addr,
        input  rd_color, rd_depth, rd_stencil, wb_done,
        output m_frag_tvalid, m_frag_tlast, m_frag_tkeep, m_frag_tcolor, m_frag_tdepth,
               m_frag_tindex, m_frag_tscreenPosX, m_frag_tscreenPosY,
               m_frag_tdestinationColor, m_frag_tdestinationDepth, m_frag_tdestinationStencil,
        input  m_frag_tready
    );

    modport master (
        output s_frag_tvalid, s_frag_tlast, s_frag_tkeep, s_frag_tcolor, s_frag_tdepth,
               s_frag_tindex, s_frag_tscreenPosX, s_frag_tscreenPosY,
        input  s_frag_tready,
        input  rd_en, rd_addr,
        output rd_color, rd_depth, rd_stencil, wb_done,
        input  m_frag_tvalid, m_frag_tlast, m_frag_tkeep, m_frag_tcolor, m_frag_tdepth,
               m_frag_tindex, m_frag_tscreenPosX, m_frag_tscreenPosY,
               m_frag_tdestinationColor, m_frag_tdestinationDepth, m_frag_tdestinationStencil,
        output m_frag_tready
    );
endinterface

// File: rtl/frag_index_scoreboard.sv
// In-order FIFO of tile-buffer indices still in flight, with a parallel compare
// of every live entry against one probe index.
module frag_index_scoreboard #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [IDX_W-1:0]       push_idx,
    input  logic                   pop,
    input  logic [IDX_W-1:0]       cmp_idx,
    output logic                   match,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][IDX_W-1:0] idx_q;
    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0]            hit;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    // Late retire pulses (e.g. from before a reset) land here with count==0 and are dropped.
    assign do_pop  = pop && (count != '0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign hit[i] = vld_q[i] && (idx_q[i] == cmp_idx);
    end
    assign match = |hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                idx_q[wr_ptr] <= push_idx;
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frag_dest_fetch.sv
// Per-fragment front end: reads tile-buffer destination data and blocks read-after-write hazards.
// Optional stall counters enabled by RASTERIX_FRAG_DEST_FETCH_PERF_CNT_EN.
module frag_dest_fetch
    import frag_dest_fetch_pkg::*;
#(
    parameter int FRAMEBUFFER_INDEX_WIDTH = DEF_FRAMEBUFFER_INDEX_WIDTH,
    parameter int SCREEN_POS_WIDTH        = DEF_SCREEN_POS_WIDTH,
    parameter int DEPTH_WIDTH             = DEF_DEPTH_WIDTH,
    parameter int STENCIL_WIDTH           = DEF_STENCIL_WIDTH,
    parameter int PIXEL_WIDTH             = DEF_PIXEL_WIDTH,
    parameter int HAZARD_DEPTH            = DEF_HAZARD_DEPTH
) (
    input  logic              aclk,
    input  logic              reset,
    frag_dest_fetch_if.slave  bus,
    output logic              idle
`ifdef RASTERIX_FRAG_DEST_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_hazard_cnt,
    output logic [31:0]       stall_full_cnt
`endif
);
    localparam int CNT_W = $clog2(HAZARD_DEPTH) + 1;

    logic             sb_match;
    logic             sb_full;
    logic [CNT_W-1:0] sb_count;
    logic             hazard;
    logic             blk_full;
    logic             s_ready;
    logic             accept;
    logic             out_vld;
    logic             fresh;

    logic                               last_q;
    logic                               keep_q;
    logic [PIXEL_WIDTH-1:0]             color_q;
    logic [FRAG_DEPTH_WIDTH-1:0]        depth_q;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] index_q;
    logic [SCREEN_POS_WIDTH-1:0]        pos_x_q;
    logic [SCREEN_POS_WIDTH-1:0]        pos_y_q;
    logic [PIXEL_WIDTH-1:0]             hold_color;
    logic [DEPTH_WIDTH-1:0]             hold_depth;
    logic [STENCIL_WIDTH-1:0]           hold_stencil;

    // Compare sees pre-pop state, so a fragment waiting on a retiring entry goes one cycle later.
    frag_index_scoreboard #(
        .DEPTH (HAZARD_DEPTH),
        .IDX_W (FRAMEBUFFER_INDEX_WIDTH)
    ) u_sb (
        .clk      (aclk),
        .reset    (reset),
        .push     (accept && bus.s_frag_tkeep),
        .push_idx (bus.s_frag_tindex),
        .pop      (bus.wb_done),
        .cmp_idx  (bus.s_frag_tindex),
        .match    (sb_match),
        .full     (sb_full),
        .count    (sb_count)
    );

    assign hazard   = bus.s_frag_tkeep && sb_match;
    assign blk_full = bus.s_frag_tkeep && sb_full;
    assign s_ready  = !hazard && !blk_full && (!out_vld || bus.m_frag_tready);
    assign accept   = bus.s_frag_tvalid && s_ready;

    assign bus.s_frag_tready = s_ready;
    assign bus.rd_en         = accept && bus.s_frag_tkeep;
    assign bus.rd_addr       = bus.s_frag_tindex;

    always_ff @(posedge aclk) begin
        if (reset) begin
            out_vld <= 1'b0;
            fresh   <= 1'b0;
        end else begin
            if (accept)
                out_vld <= 1'b1;
            else if (bus.m_frag_tready)
                out_vld <= 1'b0;
            fresh <= accept;
        end
    end

    always_ff @(posedge aclk) begin
        if (accept) begin
            last_q  <= bus.s_frag_tlast;
            keep_q  <= bus.s_frag_tkeep;
            color_q <= bus.s_frag_tcolor;
            depth_q <= bus.s_frag_tdepth;
            index_q <= bus.s_frag_tindex;
            pos_x_q <= bus.s_frag_tscreenPosX;
            pos_y_q <= bus.s_frag_tscreenPosY;
        end
        // Read data is only valid on the fresh cycle; keep a copy for stalled beats.
        if (fresh) begin
            hold_color   <= bus.rd_color;
            hold_depth   <= bus.rd_depth;
            hold_stencil <= bus.rd_stencil;
        end
    end

    assign bus.m_frag_tvalid      = out_vld;
    assign bus.m_frag_tlast       = last_q;
    assign bus.m_frag_tkeep       = keep_q;
    assign bus.m_frag_tcolor      = color_q;
    assign bus.m_frag_tdepth      = depth_q;
    assign bus.m_frag_tindex      = index_q;
    assign bus.m_frag_tscreenPosX = pos_x_q;
    assign bus.m_frag_tscreenPosY = pos_y_q;

    assign bus.m_frag_tdestinationColor   = !keep_q ? '0 : (fresh ? bus.rd_color   : hold_color);
    assign bus.m_frag_tdestinationDepth   = !keep_q ? '0 : (fresh ? bus.rd_depth   : hold_depth);
    assign bus.m_frag_tdestinationStencil = !keep_q ? '0 : (fresh ? bus.rd_stencil : hold_stencil);

    assign idle = !out_vld && (sb_count == '0);

`ifdef RASTERIX_FRAG_DEST_FETCH_PERF_CNT_EN
    always_ff @(posedge aclk) begin
        if (reset) begin
            stall_hazard_cnt <= '0;
            stall_full_cnt   <= '0;
        end else begin
            if (bus.s_frag_tvalid && hazard && (stall_hazard_cnt != '1))
                stall_hazard_cnt <= stall_hazard_cnt + 1'b1;
            if (bus.s_frag_tvalid && blk_full && (stall_full_cnt != '1))
                stall_full_cnt <= stall_full_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frag_dest_fetch.sv
// Directed bench for frag_dest_fetch: expected beats queued on accept, checked on output handshake.
// Also checks stall counters when RASTERIX_FRAG_DEST_FETCH_PERF_CNT_EN is defined.
module tb_frag_dest_fetch;

    typedef struct {
        logic [31:0] color;
        logic [31:0] depth;
        logic [13:0] index;
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
        logic        keep;
        logic [31:0] dcolor;
        logic [15:0] ddepth;
        logic [3:0]  dstencil;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic aclk;
    logic reset;
    logic idle;
`ifdef RASTERIX_FRAG_DEST_FETCH_PERF_CNT_EN
    logic [31:0] hz_cnt;
    logic [31:0] fl_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];

    frag_dest_fetch_if bus ();

    frag_dest_fetch dut (
        .aclk  (aclk),
        .reset (reset),
        .bus   (bus),
        .idle  (idle)
`ifdef RASTERIX_FRAG_DEST_FETCH_PERF_CNT_EN
        ,
        .stall_hazard_cnt (hz_cnt),
        .stall_full_cnt   (fl_cnt)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic keep, input logic [13:0] idx, output int waited);
        exp_t e;
        bit   ok;
        bus.s_frag_tvalid      = 1'b1;
        bus.s_frag_tkeep       = keep;
        bus.s_frag_tindex      = idx;
        bus.s_frag_tcolor      = 32'hC0DE0000 | 32'(idx);
        bus.s_frag_tdepth      = 32'h0001_0000 + 32'(idx);
        bus.s_frag_tlast       = idx[0];
        bus.s_frag_tscreenPosX = 16'(idx * 3);
        bus.s_frag_tscreenPosY = 16'(idx) + 16'd100;
        waited = 0;
        ok = 1'b0;
        while (1) begin
            @(negedge aclk);
            if (bus.s_frag_tready) begin
                ok = 1'b1;
                break;
            end
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 64'(waited), 64'd0);
                break;
            end
            step();
        end
        if (ok) begin
            chk("rd_en", bus.rd_en, keep);
            if (keep) chk("rd_addr", bus.rd_addr, idx);
            e.color    = bus.s_frag_tcolor;
            e.depth    = bus.s_frag_tdepth;
            e.index    = idx;
            e.x        = bus.s_frag_tscreenPosX;
            e.y        = bus.s_frag_tscreenPosY;
            e.last     = idx[0];
            e.keep     = keep;
            e.dcolor   = keep ? bus.rd_color   : 32'd0;
            e.ddepth   = keep ? bus.rd_depth   : 16'd0;
            e.dstencil = keep ? bus.rd_stencil : 4'd0;
            e.acc_cyc  = cyc;
            e.chk_lat  = bus.m_frag_tready;
            q.push_back(e);
        end
        step();
        bus.s_frag_tvalid = 1'b0;
    endtask

    task automatic retire(input int n);
        for (int i = 0; i < n; i++) begin
            bus.wb_done = 1'b1;
            step();
        end
        bus.wb_done = 1'b0;
    endtask

    // Output monitor: every completed beat must match the oldest queued expectation.
    always @(negedge aclk) begin
        if (!reset && bus.m_frag_tvalid && bus.m_frag_tready) begin
            if (q.size() == 0) begin
                chk("extra_output", 64'(bus.m_frag_tindex), 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("o_index",   bus.m_frag_tindex, e.index);
                chk("o_color",   bus.m_frag_tcolor, e.color);
                chk("o_depth",   bus.m_frag_tdepth, e.depth);
                chk("o_posx",    bus.m_frag_tscreenPosX, e.x);
                chk("o_posy",    bus.m_frag_tscreenPosY, e.y);
                chk("o_last",    bus.m_frag_tlast, e.last);
                chk("o_keep",    bus.m_frag_tkeep, e.keep);
                chk("o_dcolor",  bus.m_frag_tdestinationColor, e.dcolor);
                chk("o_ddepth",  bus.m_frag_tdestinationDepth, e.ddepth);
                chk("o_dstencil",bus.m_frag_tdestinationStencil, e.dstencil);
                if (e.chk_lat) chk("latency", 64'(cyc), 64'(e.acc_cyc + 1));
            end
        end
    end

    initial begin
        int w;
        reset = 1'b1;
        bus.s_frag_tvalid = 1'b0;
        bus.s_frag_tkeep = 1'b0;
        bus.s_frag_tlast = 1'b0;
        bus.s_frag_tindex = '0;
        bus.s_frag_tcolor = '0;
        bus.s_frag_tdepth = '0;
        bus.s_frag_tscreenPosX = '0;
        bus.s_frag_tscreenPosY = '0;
        bus.rd_color = 32'hAABBCCDD;
        bus.rd_depth = 16'h1111;
        bus.rd_stencil = 4'h3;
        bus.wb_done = 1'b0;
        bus.m_frag_tready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge aclk);
        chk("rst_tvalid", bus.m_frag_tvalid, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_rd_en", bus.rd_en, 1'b0);
        chk("rst_count", dut.u_sb.count, 4'd0);
        chk("rst_tready", bus.s_frag_tready, 1'b1);
`ifdef RASTERIX_FRAG_DEST_FETCH_PERF_CNT_EN
        chk("rst_hz_cnt", hz_cnt, 32'd0);
        chk("rst_fl_cnt", fl_cnt, 32'd0);
`endif
        step();

        // independent stream, one per cycle
        for (int i = 0; i < 4; i++) send(1'b1, 14'(i), w);
        step();
        chk("stream_count", dut.u_sb.count, 4'd4);
        retire(4);
        @(negedge aclk);
        chk("stream_drained", dut.u_sb.count, 4'd0);
        step();

        // read-after-write hazard on index 5
        send(1'b1, 14'd5, w);
        bus.s_frag_tvalid = 1'b1;
        bus.s_frag_tkeep = 1'b1;
        bus.s_frag_tindex = 14'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("hazard_stall", bus.s_frag_tready, 1'b0);
            step();
        end
        bus.wb_done = 1'b1;
        @(negedge aclk);
        chk("hazard_prepop", bus.s_frag_tready, 1'b0);
        step();
        bus.wb_done = 1'b0;
        send(1'b1, 14'd5, w);
        chk("hazard_release_wait", 64'(w), 64'd0);
`ifdef RASTERIX_FRAG_DEST_FETCH_PERF_CNT_EN
        chk("hz_cnt", hz_cnt, 32'd4);
`endif
        retire(1);

        // full scoreboard: keep=1 blocked, keep=0 passes
        for (int i = 0; i < 8; i++) send(1'b1, 14'(16 + i), w);
        chk("full_count", dut.u_sb.count, 4'd8);
        bus.s_frag_tvalid = 1'b1;
        bus.s_frag_tkeep = 1'b1;
        bus.s_frag_tindex = 14'd30;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            chk("full_stall", bus.s_frag_tready, 1'b0);
            step();
        end
        send(1'b0, 14'd30, w);
        chk("nokeep_wait", 64'(w), 64'd0);
`ifdef RASTERIX_FRAG_DEST_FETCH_PERF_CNT_EN
        chk("fl_cnt", fl_cnt, 32'd2);
`endif
        retire(1);
        send(1'b1, 14'd30, w);
        chk("full_release_wait", 64'(w), 64'd0);
        retire(8);
        @(negedge aclk);
        chk("full_drained", dut.u_sb.count, 4'd0);
        step();

        // backpressure: captured depth must survive a read-data change
        bus.m_frag_tready = 1'b0;
        bus.rd_depth = 16'h1234;
        send(1'b1, 14'd40, w);
        @(negedge aclk);
        chk("bp_fresh_depth", bus.m_frag_tdestinationDepth, 16'h1234);
        step();
        bus.rd_depth = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("bp_tvalid", bus.m_frag_tvalid, 1'b1);
            chk("bp_ddepth", bus.m_frag_tdestinationDepth, 16'h1234);
            chk("bp_index", bus.m_frag_tindex, 14'd40);
            chk("bp_color", bus.m_frag_tcolor, 32'hC0DE0028);
            chk("bp_dcolor", bus.m_frag_tdestinationColor, 32'hAABBCCDD);
            step();
        end
        bus.m_frag_tready = 1'b1;
        step();
        bus.rd_depth = 16'h1111;
        retire(1);

        // simultaneous push/pop at count 3, then spurious retire at count 0
        for (int i = 0; i < 3; i++) send(1'b1, 14'(50 + i), w);
        chk("pp_count_pre", dut.u_sb.count, 4'd3);
        bus.wb_done = 1'b1;
        send(1'b1, 14'd53, w);
        bus.wb_done = 1'b0;
        @(negedge aclk);
        chk("pp_count", dut.u_sb.count, 4'd3);
        step();
        retire(3);
        retire(1);
        @(negedge aclk);
        chk("underflow_count", dut.u_sb.count, 4'd0);
        chk("underflow_idle", idle, 1'b1);
        step();

        // reset with 4 in flight and an output beat stalled
        for (int i = 0; i < 3; i++) send(1'b1, 14'(60 + i), w);
        step();
        bus.m_frag_tready = 1'b0;
        send(1'b1, 14'd63, w);
        @(negedge aclk);
        chk("prerst_count", dut.u_sb.count, 4'd4);
        chk("prerst_tvalid", bus.m_frag_tvalid, 1'b1);
        step();
        reset = 1'b1;
        q.delete();
        step();
        reset = 1'b0;
        @(negedge aclk);
        chk("midrst_tvalid", bus.m_frag_tvalid, 1'b0);
        chk("midrst_idle", idle, 1'b1);
        chk("midrst_count", dut.u_sb.count, 4'd0);
        step();
        bus.m_frag_tready = 1'b1;
        retire(2);
        @(negedge aclk);
        chk("postrst_count", dut.u_sb.count, 4'd0);
        step();

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
